bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the 8-digit seven-segment display multiplexer. Its registered BCD output feeds the mux's hex7..hex0 inputs, so counters and measured values can be shown in decimal. A start/ready/done handshake lets the producing logic trigger conversions at its own rate.

Parameters:
BIN_W, 27, width of binary input; default covers 0..99,999,999
DIGITS, 8, number of BCD digits produced (matches the 8-digit display)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request conversion; sampled only when ready=1
bin  input  BIN_W  binary value; sampled on the accepting edge only
ready  output  1  high when idle and able to accept start
done_tick  output  1  one-cycle pulse when bcd/ovf update
bcd  output  4*DIGITS  result; digit i occupies bits [4i+3:4i], digit 0 is least significant
ovf  output  1  last conversion exceeded 10^DIGITS-1

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, ready=1, done_tick=0, bcd=0, ovf=0, internal shift/BCD work regs=0, bit counter=0.
- FSM states:
  - IDLE: ready=1. On an edge with start=1:
    - load bin into shift register;
    - clear the BCD work register;
    - counter=BIN_W;
    - latch ovf_pending=(bin >= 10^DIGITS);
    - go to OP.
  - OP: ready=0. Each edge:
    - add 3 to every work digit >= 5;
    - shift the work register left by 1 with the shift register MSB as input;
    - shift the shift register left by 1;
    - decrement the counter.
  - OP exit: on the edge where the counter goes 1->0, transfer the corrected result to bcd and ovf, set done_tick=1, and go to IDLE.
- Latency: if start is accepted at edge k, bcd/ovf/done_tick update at edge k+BIN_W. done_tick is high for exactly one cycle. Earliest next accept is edge k+BIN_W+1, so throughput is one conversion per BIN_W+1 cycles.
- Output stability:
  - bcd and ovf hold the previous result for the whole conversion, so the display never shows partial values.
  - bcd and ovf change only on done_tick or reset.
- Overflow:
  - The conversion still runs full length, keeping latency uniform.
  - At completion with ovf_pending=1: bcd = all digits 4'h9, ovf=1.
  - Otherwise ovf=0 and bcd is the exact decimal value.
- start while ready=0 is ignored: no queuing, and bin changes during OP have no effect.
- start held high continuously gives back-to-back conversions, each re-sampling bin at its accept edge.
- Reset mid-conversion: immediately returns to IDLE with bcd=0 and ovf=0. No done_tick is produced for the aborted conversion.
- Arithmetic and widths:
  - The add-3 correction applies per 4-bit digit, combinationally, before each shift.
  - Work register width is 4*DIGITS; no bits beyond digit DIGITS-1 are kept.
  - The 10^DIGITS compare constant is computed at elaboration, wide enough for BIN_W.
- Every bcd digit is always in 0..9, so the downstream mux never sees A..F from this block.

Test Plan:
- Reset then idle:
  - Required: ready=1, bcd=32'h00000000, ovf=0, done_tick=0.
  - Then start with bin=0 -> done_tick exactly 27 cycles after the accept edge, bcd=32'h00000000.
- bin=12345678 -> bcd=32'h12345678, ovf=0. bcd unchanged from its prior value during all 27 OP cycles.
- Boundaries:
  - bin=99999999 -> bcd=32'h99999999, ovf=0.
  - bin=9 -> 32'h00000009.
  - bin=10 -> 32'h00000010.
- Overflow:
  - bin=100000000 -> bcd=32'h99999999, ovf=1.
  - Next conversion of bin=42 -> bcd=32'h00000042, ovf=0.
- Ignored and back-to-back starts:
  - start=1 with bin=555 accepted; pulse start with bin=777 mid-conversion -> result 32'h00000555 and a single done_tick.
  - start held high -> accepts every 28 cycles.
- Reset mid-conversion: assert reset_n=0 at OP cycle 10 -> bcd=0, ready=1 asynchronously, and no done_tick afterwards.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Feeds the 8-digit display mux. bcd/ovf only change on done_tick or reset,
// so the display never shows a partially converted value.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 27,
    parameter int unsigned DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  done_tick,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    // Headroom so the 10^DIGITS constant never wraps.
    localparam int unsigned CMP_W = BIN_W + 64;

    // 10^n, saturating once it already exceeds every BIN_W-bit input.
    function automatic logic [CMP_W-1:0] pow10(input int unsigned n);
        logic [CMP_W-1:0] p;
        p = {{(CMP_W-1){1'b0}}, 1'b1};
        for (int unsigned i = 0; i < n; i++) begin
            if (p[CMP_W-1:BIN_W] == '0) begin
                p = (p << 3) + (p << 1);
            end
        end
        return p;
    endfunction

    localparam logic [CMP_W-1:0] LIMIT = pow10(DIGITS);
    localparam logic [BCD_W-1:0] ALL9  = {DIGITS{4'h9}};

    typedef enum logic [0:0] {StIdle, StOp} state_e;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   work_adj;
    logic [BCD_W-1:0]   work_shift;

    // Add-3 correction on every digit >= 5, then shift in the next binary bit.
    always_comb begin
        work_adj = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end else begin
                work_adj[4*i +: 4] = work_q[4*i +: 4];
            end
        end
        work_shift = {work_adj[BCD_W-2:0], shift_q[BIN_W-1]};
    end

    // Next-state: accept in idle, one shift per cycle, publish result on last shift.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d    = bin;
                    work_d     = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_pend_d = ({{64{1'b0}}, bin} >= LIMIT);
                    state_d    = StOp;
                end
            end
            StOp: begin
                work_d  = work_shift;
                shift_d = {shift_q[BIN_W-2:0], 1'b0};
                cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    bcd_d   = ovf_pend_q ? ALL9 : work_shift;
                    ovf_d   = ovf_pend_q;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset aborts any conversion silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign ready     = (state_q == StIdle);
    assign done_tick = done_q;
    assign bcd       = bcd_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq with hand-computed expected results.
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [26:0] bin;
    logic        ready;
    logic        done_tick;
    logic [31:0] bcd;
    logic        ovf;

    int total;
    int bad;

    bin2bcd_seq #(
        .BIN_W  (27),
        .DIGITS (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bin       (bin),
        .ready     (ready),
        .done_tick (done_tick),
        .bcd       (bcd),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion: checks latency, output stability and result.
    task automatic run_conv(input logic [26:0] v, input logic [31:0] exp_bcd,
                            input logic exp_ovf, input string tag);
        logic [31:0] prev_bcd;
        logic        prev_ovf;
        logic        stable;
        int          n;
        prev_bcd = bcd;
        prev_ovf = ovf;
        stable   = 1'b1;
        chk({tag, "_ready_before"}, 64'(ready), 64'd1);
        start = 1'b1;
        bin   = v;
        tick();
        start = 1'b0;
        bin   = 27'h5a5a5a5;
        n = 0;
        while (!done_tick && n < 40) begin
            if (bcd !== prev_bcd || ovf !== prev_ovf) stable = 1'b0;
            chk({tag, "_ready_busy"}, 64'(ready), 64'd0);
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd27);
        chk({tag, "_stable"}, 64'(stable), 64'd1);
        chk({tag, "_bcd"}, 64'(bcd), 64'(exp_bcd));
        chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        tick();
        chk({tag, "_done_pulse"}, 64'(done_tick), 64'd0);
        chk({tag, "_ready_after"}, 64'(ready), 64'd1);
        chk({tag, "_bcd_hold"}, 64'(bcd), 64'(exp_bcd));
    endtask

    initial begin
        int n;
        int dones;
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        bin     = '0;

        // Reset state.
        tick();
        tick();
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_bcd", 64'(bcd), 64'h0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_done", 64'(done_tick), 64'd0);
        #2 reset_n = 1'b1;
        tick();
        chk("idle_ready", 64'(ready), 64'd1);

        // Main function and boundaries.
        run_conv(27'd0,         32'h00000000, 1'b0, "zero");
        run_conv(27'd12345678,  32'h12345678, 1'b0, "mid");
        run_conv(27'd99999999,  32'h99999999, 1'b0, "max_ok");
        run_conv(27'd9,         32'h00000009, 1'b0, "nine");
        run_conv(27'd10,        32'h00000010, 1'b0, "ten");
        run_conv(27'd100000000, 32'h99999999, 1'b1, "ovf_min");
        run_conv(27'd42,        32'h00000042, 1'b0, "after_ovf");
        run_conv(27'h7ffffff,   32'h99999999, 1'b1, "ovf_top");
        run_conv(27'd90817263,  32'h90817263, 1'b0, "mixed");

        // Start during conversion is ignored.
        start = 1'b1;
        bin   = 27'd555;
        tick();
        start = 1'b0;
        n     = 1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) begin
                start = 1'b1;
                bin   = 27'd777;
            end else begin
                start = 1'b0;
            end
            if (done_tick) begin
                dones++;
                chk("ign_latency", 64'(n - 1), 64'd27);
            end
            tick();
            n++;
        end
        start = 1'b0;
        chk("ign_dones", 64'(dones), 64'd1);
        chk("ign_bcd", 64'(bcd), 64'h00000555);
        chk("ign_ovf", 64'(ovf), 64'd0);

        // Back-to-back conversions with start held high.
        start = 1'b1;
        bin   = 27'd11;
        tick();
        bin = 27'd22;
        n = 0;
        while (!done_tick && n < 40) begin
            tick();
            n++;
        end
        chk("b2b_lat1", 64'(n), 64'd27);
        chk("b2b_bcd1", 64'(bcd), 64'h00000011);
        chk("b2b_ready_at_done", 64'(ready), 64'd1);
        tick();
        bin = 27'd33;
        n = 1;
        while (!done_tick && n < 40) begin
            tick();
            n++;
        end
        start = 1'b0;
        chk("b2b_period", 64'(n), 64'd28);
        chk("b2b_bcd2", 64'(bcd), 64'h00000022);
        tick();
        chk("b2b_done_pulse", 64'(done_tick), 64'd0);
        chk("b2b_ready_end", 64'(ready), 64'd1);

        // Reset in the middle of a conversion.
        start = 1'b1;
        bin   = 27'd5000;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_rst_busy", 64'(ready), 64'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_bcd", 64'(bcd), 64'h0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        chk("mid_rst_ready", 64'(ready), 64'd1);
        chk("mid_rst_done", 64'(done_tick), 64'd0);
        tick();
        #2 reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_tick) dones++;
            tick();
        end
        chk("mid_rst_no_done", 64'(dones), 64'd0);
        chk("mid_rst_bcd_hold", 64'(bcd), 64'h0);

        // Converter usable again after the abort.
        run_conv(27'd2024, 32'h00002024, 1'b0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
